// File: rtl/mem_bridge_pkg.sv
// rtl/mem_bridge_pkg.sv - shared sizes, widths and FSM states for mem_req_bridge
package mem_bridge_pkg;

  localparam int MEM_AW = 9;
  localparam int MEM_DW = 16;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD0  = 3'd1,
    ST_RD1  = 3'd2,
    ST_CAP  = 3'd3,
    ST_WR0  = 3'd4,
    ST_WR1  = 3'd5,
    ST_RSP  = 3'd6
  } state_t;

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - lane select and sign/zero extension of captured load data
module load_extend
  import mem_bridge_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  size,
  input  logic        lane,
  input  logic        uns,
  output logic [31:0] rdata
);

  logic [7:0] byte_sel;

  always_comb begin
    byte_sel = lane ? data[15:8] : data[7:0];
    case (size)
      SZ_BYTE: rdata = {{24{~uns & byte_sel[7]}}, byte_sel};
      SZ_HALF: rdata = {{16{~uns & data[15]}}, data[15:0]};
      default: rdata = data;
    endcase
  end

endmodule

// File: rtl/mem_req_bridge.sv
// rtl/mem_req_bridge.sv - load/store request front-end sequencing 16-bit Memory accesses
// Optional misalignment error responses: MEM_REQ_BRIDGE_ALIGN_CHECK_EN
module mem_req_bridge
  import mem_bridge_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [MEM_AW:0]   req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_rw_enable,
  output logic [MEM_AW-1:0] mem_address,
  output logic [MEM_DW-1:0] mem_data_in,
  input  logic [MEM_DW-1:0] mem_data_out
);

  state_t              state, state_nxt;
  logic                cap_we, cap_uns;
  logic [1:0]          cap_size;
  logic [MEM_AW:0]     cap_addr;
  logic [31:0]         cap_wdata;
  logic [MEM_DW-1:0]   cap_lo;
  logic [1:0]          req_size_n;
  logic [MEM_AW:0]     req_addr_n;
  logic [MEM_AW-1:0]   hw_idx;
  logic [31:0]         ext_in, ext_out;
  logic                accept;

  assign accept = (state == ST_IDLE) && req_valid;

  always_comb begin
    req_size_n = (req_size == 2'd3) ? SZ_WORD : req_size;
    req_addr_n = req_addr;
`ifndef MEM_REQ_BRIDGE_ALIGN_CHECK_EN
    if (req_size_n == SZ_WORD)
      req_addr_n[1:0] = 2'b00;
    else if (req_size_n == SZ_HALF)
      req_addr_n[0] = 1'b0;
`endif
  end

`ifdef MEM_REQ_BRIDGE_ALIGN_CHECK_EN
  logic req_mis;
  logic rsp_err_q;
  assign req_mis = ((req_size_n == SZ_WORD) && (req_addr[1:0] != 2'b00)) ||
                   ((req_size_n == SZ_HALF) && req_addr[0]);
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (req_valid) begin
        // Byte stores need the old halfword first, so they start with a read
        if (req_we && (req_size_n != SZ_BYTE)) state_nxt = ST_WR0;
        else                                   state_nxt = ST_RD0;
`ifdef MEM_REQ_BRIDGE_ALIGN_CHECK_EN
        if (req_mis) state_nxt = ST_RSP;
`endif
      end
      ST_RD0:  state_nxt = (!cap_we && (cap_size == SZ_WORD)) ? ST_RD1 : ST_CAP;
      ST_RD1:  state_nxt = ST_CAP;
      ST_CAP:  state_nxt = cap_we ? ST_WR0 : ST_RSP;
      ST_WR0:  state_nxt = (cap_size == SZ_WORD) ? ST_WR1 : ST_RSP;
      ST_WR1:  state_nxt = ST_RSP;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cap_we    <= 1'b0;
      cap_uns   <= 1'b0;
      cap_size  <= SZ_BYTE;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_lo    <= '0;
      rsp_rdata <= '0;
`ifdef MEM_REQ_BRIDGE_ALIGN_CHECK_EN
      rsp_err_q <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        cap_we    <= req_we;
        cap_uns   <= req_unsigned;
        cap_size  <= req_size_n;
        cap_addr  <= req_addr_n;
        cap_wdata <= req_wdata;
      end
      if ((state == ST_RD1) || ((state == ST_CAP) && cap_we))
        cap_lo <= mem_data_out;
      if ((state == ST_CAP) && !cap_we)
        rsp_rdata <= ext_out;
      if (((state == ST_WR0) && (state_nxt == ST_RSP)) || (state == ST_WR1))
        rsp_rdata <= '0;
`ifdef MEM_REQ_BRIDGE_ALIGN_CHECK_EN
      if (state_nxt == ST_RSP)
        rsp_err_q <= 1'b0;
      if (accept && req_mis) begin
        rsp_rdata <= '0;
        rsp_err_q <= 1'b1;
      end
`endif
    end
  end

  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RSP);
  assign hw_idx    = cap_addr[MEM_AW:1];

  // Memory output is one cycle late: in CAP it holds the last halfword read
  assign ext_in = (cap_size == SZ_WORD) ? {mem_data_out, cap_lo} : {16'h0000, mem_data_out};

  load_extend u_load_extend (
    .data  (ext_in),
    .size  (cap_size),
    .lane  (cap_addr[0]),
    .uns   (cap_uns),
    .rdata (ext_out)
  );

  always_comb begin
    mem_rw_enable = 1'b1;
    mem_address   = '0;
    mem_data_in   = '0;
    case (state)
      ST_RD0: mem_address = hw_idx;
      ST_RD1: mem_address = hw_idx + 1'b1;
      ST_WR0: begin
        mem_rw_enable = 1'b0;
        mem_address   = hw_idx;
        if (cap_size == SZ_BYTE)
          mem_data_in = cap_addr[0] ? {cap_wdata[7:0], cap_lo[7:0]}
                                    : {cap_lo[15:8], cap_wdata[7:0]};
        else
          mem_data_in = cap_wdata[15:0];
      end
      ST_WR1: begin
        mem_rw_enable = 1'b0;
        mem_address   = hw_idx + 1'b1;
        mem_data_in   = cap_wdata[31:16];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_req_bridge.sv
// tb/tb_mem_req_bridge.sv - directed-vector bench for mem_req_bridge with a 512x16 Memory model
module tb_mem_req_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [9:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_rw_enable;
  logic [8:0]  mem_address;
  logic [15:0] mem_data_in;
  logic [15:0] mem_data_out;

  logic [15:0] mem [512];

  int n_vec  = 0;
  int n_miss = 0;

  logic [31:0] rd;
  logic        er;
  int          lat;
  logic        wrote;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!mem_rw_enable) mem[mem_address] <= mem_data_in;
    mem_data_out <= mem[mem_address];
  end

  mem_req_bridge dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_size      (req_size),
    .req_unsigned  (req_unsigned),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .rsp_err       (rsp_err),
    .mem_rw_enable (mem_rw_enable),
    .mem_address   (mem_address),
    .mem_data_in   (mem_data_in),
    .mem_data_out  (mem_data_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [9:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err,
                        output int latency, output logic wr_seen);
    @(negedge clk);
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    req_valid    = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    latency = 0;
    wr_seen = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (!mem_rw_enable) wr_seen = 1'b1;
      if (rsp_valid) begin
        latency = i;
        break;
      end
    end
    rdata = rsp_rdata;
    err   = rsp_err;
    if (latency == 0) check("rsp_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("rst_rw_enable", {31'd0, mem_rw_enable}, 32'd1);
    check("rst_mem_address", {23'd0, mem_address}, 32'd0);
    check("rst_mem_data_in", {16'd0, mem_data_in}, 32'd0);

    do_req(1'b1, 2'd2, 1'b0, 10'h010, 32'h89ABCDEF, rd, er, lat, wrote);
    check("sw_lat", lat, 32'd3);
    check("sw_rdata", rd, 32'd0);
    check("sw_mem8", {16'd0, mem[8]}, 32'h0000CDEF);
    check("sw_mem9", {16'd0, mem[9]}, 32'h000089AB);

    do_req(1'b0, 2'd2, 1'b0, 10'h010, 32'h0, rd, er, lat, wrote);
    check("lw_lat", lat, 32'd4);
    check("lw_rdata", rd, 32'h89ABCDEF);

    do_req(1'b1, 2'd0, 1'b0, 10'h011, 32'h0000005A, rd, er, lat, wrote);
    check("sb_lat", lat, 32'd4);
    check("sb_mem8", {16'd0, mem[8]}, 32'h00005AEF);
    check("sb_mem9", {16'd0, mem[9]}, 32'h000089AB);

    do_req(1'b0, 2'd0, 1'b0, 10'h011, 32'h0, rd, er, lat, wrote);
    check("lb_011_lat", lat, 32'd3);
    check("lb_011", rd, 32'h0000005A);
    do_req(1'b0, 2'd0, 1'b0, 10'h013, 32'h0, rd, er, lat, wrote);
    check("lb_013", rd, 32'hFFFFFF89);
    do_req(1'b0, 2'd0, 1'b1, 10'h013, 32'h0, rd, er, lat, wrote);
    check("lbu_013", rd, 32'h00000089);
    do_req(1'b0, 2'd0, 1'b0, 10'h010, 32'h0, rd, er, lat, wrote);
    check("lb_010", rd, 32'hFFFFFFEF);

    do_req(1'b0, 2'd1, 1'b0, 10'h012, 32'h0, rd, er, lat, wrote);
    check("lh_lat", lat, 32'd3);
    check("lh_012", rd, 32'hFFFF89AB);
    do_req(1'b0, 2'd1, 1'b1, 10'h012, 32'h0, rd, er, lat, wrote);
    check("lhu_012", rd, 32'h000089AB);

    do_req(1'b1, 2'd3, 1'b0, 10'h3FC, 32'h43211234, rd, er, lat, wrote);
    check("sw_top_lat", lat, 32'd3);
    check("sw_mem1fe", {16'd0, mem[9'h1FE]}, 32'h00001234);
    check("sw_mem1ff", {16'd0, mem[9'h1FF]}, 32'h00004321);
    do_req(1'b0, 2'd2, 1'b0, 10'h3FC, 32'h0, rd, er, lat, wrote);
    check("lw_top", rd, 32'h43211234);

    do_req(1'b0, 2'd2, 1'b0, 10'h012, 32'h0, rd, er, lat, wrote);
`ifdef MEM_REQ_BRIDGE_ALIGN_CHECK_EN
    check("mis_lat", lat, 32'd1);
    check("mis_err", {31'd0, er}, 32'd1);
    check("mis_rdata", rd, 32'd0);
    check("mis_no_write", {31'd0, wrote}, 32'd0);
`else
    check("mis_lat", lat, 32'd4);
    check("mis_err", {31'd0, er}, 32'd0);
    check("mis_rdata", rd, 32'h89AB5AEF);
`endif

    // abort a word load in RD1 with an asynchronous reset
    @(negedge clk);
    req_we    = 1'b0;
    req_size  = 2'd2;
    req_addr  = 10'h010;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_req_ready", {31'd0, req_ready}, 32'd1);
    check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("abort_rsp_rdata", rsp_rdata, 32'd0);
    check("abort_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("abort_rw_enable", {31'd0, mem_rw_enable}, 32'd1);
    check("abort_mem_address", {23'd0, mem_address}, 32'd0);
    check("abort_mem_data_in", {16'd0, mem_data_in}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_no_rsp_after", {31'd0, rsp_valid}, 32'd0);
    check("abort_ready_after", {31'd0, req_ready}, 32'd1);

    do_req(1'b1, 2'd1, 1'b0, 10'h020, 32'h0000BEEF, rd, er, lat, wrote);
    check("sh_lat", lat, 32'd2);
    check("sh_mem10", {16'd0, mem[9'h010]}, 32'h0000BEEF);
    check("sh_rdata", rd, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
